// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell reused by the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain combinational sum and carry.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, with a
// registered carry fed back between bits.
// Optional macro SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    // Only WIDTH-1 partial sum bits are stored; the MSB comes straight
    // from the adder on the final step.
    logic [WIDTH-2:0]   sum_sh_q, sum_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_out_q, sum_out_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   sum_full;

    full_adder u_full_adder (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign sum_full = {fa_sum, sum_sh_q};

    // Next-state and datapath decisions for load, shift and completion.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        carry_d   = carry_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sum_out_d = sum_out_q;
        cout_d    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_sh_d    = a_in;
                    b_sh_d    = b_in;
                    carry_d   = cin;
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                sum_sh_d  = (WIDTH-1)'(sum_full >> 1);
                carry_d   = fa_cout;
                bit_cnt_d = bit_cnt_q + 1'b1;
                busy_d    = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    sum_out_d = sum_full;
                    cout_d    = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB.
                    ovf_d     = carry_q ^ fa_cout;
`endif
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            carry_q   <= 1'b0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_out_q <= '0;
            cout_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_sh_q  <= sum_sh_d;
            carry_q   <= carry_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sum_out_q <= sum_out_d;
            cout_q    <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum_out  = sum_out_q;
    assign cout_out = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf      = ovf_q;
`endif

endmodule
